// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes,
// ALU-op codes, the control word, and the ALU decoder that consumes alu_op.
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [2:0] ALUCTL_AND = 3'b000;
  localparam logic [2:0] ALUCTL_OR  = 3'b001;
  localparam logic [2:0] ALUCTL_ADD = 3'b010;
  localparam logic [2:0] ALUCTL_SUB = 3'b110;
  localparam logic [2:0] ALUCTL_SLT = 3'b111;

  typedef struct packed {
    logic       ir_write;
    logic       pc_en;
    logic       mem_write;
    logic       reg_write;
    logic       iord;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
  } ctrl_t;

  // ALU decoder: add/sub forced by alu_op, otherwise chosen by the funct field.
  function automatic logic [2:0] alu_ctl(input logic [1:0] alu_op, input logic [5:0] funct);
    logic [2:0] ctl;
    ctl = ALUCTL_ADD;
    case (alu_op)
      ALUOP_ADD: ctl = ALUCTL_ADD;
      ALUOP_SUB: ctl = ALUCTL_SUB;
      default: begin
        case (funct)
          6'b100000: ctl = ALUCTL_ADD;
          6'b100010: ctl = ALUCTL_SUB;
          6'b100100: ctl = ALUCTL_AND;
          6'b100101: ctl = ALUCTL_OR;
          6'b101010: ctl = ALUCTL_SLT;
          default:   ctl = ALUCTL_ADD;
        endcase
      end
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/mc_out_dec.sv
// Combinational control-word decode from the current state; only FETCH and
// BEQEX look at the mem_ready / zero inputs.
module mc_out_dec
  import mips_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  input  logic   zero,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.ir_write  = mem_ready;
        ctrl.pc_en     = mem_ready;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = PCSRC_ALU;
      end
      DECODE: begin
        ctrl.alu_src_b = SRCB_BRANCH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEMRD: ctrl.iord = 1'b1;
      MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      RTYPEEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      BEQEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.pc_en     = zero;
      end
      ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ADDIWB: ctrl.reg_write = 1'b1;
      JEX: begin
        ctrl.pc_src = PCSRC_JUMP;
        ctrl.pc_en  = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control FSM: state register, next-state decode and the
// reset gating of the write enables.
//   state   | meaning
//   FETCH   | read instruction, PC+4; waits on mem_ready
//   DECODE  | register read, branch target; dispatch on opcode
//   MEMADR  | lw/sw address compute
//   MEMRD   | load data read; waits on mem_ready
//   MEMWB   | load write-back
//   MEMWR   | store write; waits on mem_ready
//   RTYPEEX | R-type execute
//   RTYPEWB | R-type write-back
//   BEQEX   | compare, branch if zero
//   ADDIEX  | addi execute
//   ADDIWB  | addi write-back
//   JEX     | jump
module mc_control_fsm
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       ir_write,
  output logic       pc_en,
  output logic       mem_write,
  output logic       reg_write,
  output logic       iord,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op,
  output logic       illegal_op
);

  state_t state;
  state_t state_next;
  logic   illegal_dec;
  ctrl_t  ctrl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = FETCH;
    illegal_dec = 1'b0;
    case (state)
      FETCH:  state_next = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = RTYPEEX;
          OP_BEQ:       state_next = BEQEX;
          OP_ADDI:      state_next = ADDIEX;
          OP_J:         state_next = JEX;
          default: begin
            illegal_dec = 1'b1;
            state_next  = FETCH;
          end
        endcase
      end
      MEMADR:  state_next = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   state_next = mem_ready ? MEMWB : MEMRD;
      MEMWB:   state_next = FETCH;
      MEMWR:   state_next = mem_ready ? FETCH : MEMWR;
      RTYPEEX: state_next = RTYPEWB;
      RTYPEWB: state_next = FETCH;
      BEQEX:   state_next = FETCH;
      ADDIEX:  state_next = ADDIWB;
      ADDIWB:  state_next = FETCH;
      JEX:     state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  mc_out_dec u_out_dec (
    .state     (state),
    .mem_ready (mem_ready),
    .zero      (zero),
    .ctrl      (ctrl)
  );

  // rst gates the enables directly so FETCH's mem_ready-driven writes stay low
  // for the whole time reset is held, not just after the next clock.
  assign ir_write   = ctrl.ir_write  & ~rst;
  assign pc_en      = ctrl.pc_en     & ~rst;
  assign mem_write  = ctrl.mem_write & ~rst;
  assign reg_write  = ctrl.reg_write & ~rst;
  assign illegal_op = illegal_dec    & ~rst;

  assign iord       = ctrl.iord;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_dst    = ctrl.reg_dst;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign pc_src     = ctrl.pc_src;
  assign alu_op     = ctrl.alu_op;

endmodule
